// File: rtl/riscv_button_event_decoder.sv
// ----------------------------------------------------------------------------
// riscv_button_event_decoder
//
// Purpose:
//   Turns the clean, debounced button level into single-cycle event pulses
//   (press, release, single click, double click, long press) for the core's
//   UART/GPIO control logic. Lives in the same clock domain as the debouncer,
//   so btn_in is used directly without synchronisation.
//
// Parameters:
//   LONG_CYCLES  cycles held in a press state before long_press fires
//   GAP_CYCLES   max released cycles after a short press to accept a 2nd press
//   CNT_W        timer width, derived from the larger of the two
//
// Ports:
//   clk            in   1  system clock, rising edge
//   reset          in   1  asynchronous, active-low reset (0 = reset)
//   btn_in         in   1  debounced button level, synchronous to clk
//   press_pulse    out  1  1-cycle pulse on each accepted 0->1 of btn_in
//   release_pulse  out  1  1-cycle pulse on each accepted 1->0 of btn_in
//   single_click   out  1  1-cycle pulse: short press, no 2nd press in gap
//   double_click   out  1  1-cycle pulse: release ending a short 2nd press
//   long_press     out  1  1-cycle pulse: press held LONG_CYCLES cycles
//   held           out  1  level: FSM in PRESSED, SECOND or LONG_HELD
//   press_count    out  8  total press_pulse count (BTN_EVT_COUNT_EN only)
//
// Configuration:
//   BTN_EVT_COUNT_EN  when defined, adds the press_count port and its 8-bit
//                     wrapping counter. When undefined, the port and counter
//                     are absent and everything else is unchanged.
//
// Handshake: none. btn_in is a level sampled every rising edge; every output
// is registered and reflects the decision taken at the previous edge
// (latency 1). Pulse outputs are high for exactly one cycle per event.
// ----------------------------------------------------------------------------
module riscv_button_event_decoder #(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 25_000_000,
    parameter int CNT_W       = $clog2(((LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES) + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       single_click,
    output logic       double_click,
    output logic       long_press,
    output logic       held
`ifdef BTN_EVT_COUNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESSED   = 3'd1,
        S_WAIT_GAP  = 3'd2,
        S_SECOND    = 3'd3,
        S_LONG_HELD = 3'd4
    } state_t;

    // Terminal timer values: the timeout fires on the edge where the timer
    // already holds N-1, i.e. N cycles after entering the state.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   timer_q;

    logic press_d;
    logic release_d;
    logic single_d;
    logic double_d;
    logic long_d;
    logic held_d;

    // ------------------------------------------------------------------
    // Next-state and next-output decode. In every state the level check
    // is tested before the timer, so a level change on the same edge as a
    // timeout wins and the timeout event is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        single_d  = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (btn_in) begin
                    state_d = S_PRESSED;
                    press_d = 1'b1;
                end
            end

            S_PRESSED: begin
                if (!btn_in) begin
                    state_d   = S_WAIT_GAP;
                    release_d = 1'b1;
                end else if (timer_q == LONG_LAST) begin
                    state_d = S_LONG_HELD;
                    long_d  = 1'b1;
                end
            end

            S_LONG_HELD: begin
                // A long press never turns into a click on release.
                if (!btn_in) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                end
            end

            S_WAIT_GAP: begin
                if (btn_in) begin
                    state_d = S_SECOND;
                    press_d = 1'b1;
                end else if (timer_q == GAP_LAST) begin
                    state_d  = S_IDLE;
                    single_d = 1'b1;
                end
            end

            S_SECOND: begin
                if (!btn_in) begin
                    state_d   = S_IDLE;
                    release_d = 1'b1;
                    double_d  = 1'b1;
                end else if (timer_q == LONG_LAST) begin
                    state_d = S_LONG_HELD;
                    long_d  = 1'b1;
                end
            end

            default: begin
                // Unused encodings recover silently to IDLE.
                state_d = S_IDLE;
            end
        endcase
    end

    // held is registered from the next state so it lines up with state_q.
    always_comb begin
        held_d = (state_d == S_PRESSED) || (state_d == S_SECOND) ||
                 (state_d == S_LONG_HELD);
    end

    // ------------------------------------------------------------------
    // State register and timer. The timer restarts at 0 on every state
    // change and otherwise counts up, sticking at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_q != {CNT_W{1'b1}}) begin
                timer_q <= timer_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            single_click  <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= press_d;
            release_pulse <= release_d;
            single_click  <= single_d;
            double_click  <= double_d;
            long_press    <= long_d;
            held          <= held_d;
        end
    end

`ifdef BTN_EVT_COUNT_EN
    // Counts in step with press_pulse so the count and the pulse appear on
    // the same cycle. Wraps 255 -> 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_count <= 8'd0;
        end else if (press_d) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_button_event_decoder.sv
// ----------------------------------------------------------------------------
// tb_riscv_button_event_decoder
//
// Bench for riscv_button_event_decoder with LONG_CYCLES=8, GAP_CYCLES=4.
// Stimulus pushes expected events, each tagged with the rising-edge index
// that should cause it, into exp_q; an independent monitor pops and checks
// one entry every time the DUT shows any pulse.
// Event vector layout: {press, release, single, double, long}.
// ----------------------------------------------------------------------------
module tb_riscv_button_event_decoder;

    localparam int EW = 37;

    localparam logic [4:0] EV_P = 5'b10000;
    localparam logic [4:0] EV_R = 5'b01000;
    localparam logic [4:0] EV_S = 5'b00100;
    localparam logic [4:0] EV_D = 5'b00010;
    localparam logic [4:0] EV_L = 5'b00001;

    logic clk;
    logic reset;
    logic btn_in;
    logic press_pulse;
    logic release_pulse;
    logic single_click;
    logic double_click;
    logic long_press;
    logic held;
`ifdef BTN_EVT_COUNT_EN
    logic [7:0] press_count;
`endif

    logic [EW-1:0] exp_q[$];
    int edge_cnt    = 0;
    int total       = 0;
    int bad         = 0;
    int exp_presses = 0;

    riscv_button_event_decoder #(
        .LONG_CYCLES(8),
        .GAP_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .held         (held)
`ifdef BTN_EVT_COUNT_EN
        ,
        .press_count  (press_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got time=%0t want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            btn_in = b;
            @(negedge clk);
        end
    endtask

    task automatic push_ev(input int e, input logic [4:0] ev);
        exp_q.push_back({32'(e), ev});
        if (ev[4]) exp_presses++;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [4:0]    ev;
        logic [EW-1:0] e;
        if (reset === 1'b1) begin
            ev = {press_pulse, release_pulse, single_click, double_click, long_press};
            if (ev != 5'b0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL evt_unexpected: got edge=%0d ev=%b want none", edge_cnt, ev);
                end else begin
                    e = exp_q.pop_front();
                    if (e !== {32'(edge_cnt), ev}) begin
                        bad++;
                        $display("FAIL evt: got edge=%0d ev=%b want edge=%0d ev=%b",
                                 edge_cnt, ev, e[36:5], e[4:0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        reset  = 1'b0;
        btn_in = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        total++;
        if ({press_pulse, release_pulse, single_click, double_click, long_press, held} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outs: got %b want 000000",
                     {press_pulse, release_pulse, single_click, double_click, long_press, held});
        end
        reset = 1'b1;
        drive(1'b0, 2);

        // 1) 3-cycle press -> press, release +3, single +4 after release
        t0 = edge_cnt + 1;
        push_ev(t0, EV_P);
        push_ev(t0 + 3, EV_R);
        push_ev(t0 + 7, EV_S);
        drive(1'b1, 3);
        check_bit("held_short", held, 1'b1);
        drive(1'b0, 10);
        check_bit("held_idle1", held, 1'b0);

        // 2) two 2-cycle presses, 2 low cycles apart -> double click
        t0 = edge_cnt + 1;
        push_ev(t0, EV_P);
        push_ev(t0 + 2, EV_R);
        push_ev(t0 + 4, EV_P);
        push_ev(t0 + 6, EV_R | EV_D);
        drive(1'b1, 2);
        drive(1'b0, 2);
        drive(1'b1, 2);
        drive(1'b0, 8);

        // 3) held 12 cycles -> long press 8 cycles after press
        t0 = edge_cnt + 1;
        push_ev(t0, EV_P);
        push_ev(t0 + 8, EV_L);
        push_ev(t0 + 12, EV_R);
        for (int i = 0; i < 12; i++) begin
            btn_in = 1'b1;
            @(negedge clk);
            check_bit("held_long", held, 1'b1);
        end
        drive(1'b0, 4);
        check_bit("held_idle3", held, 1'b0);

        // 4) second press on the gap-expiry edge: press wins, no single
        t0 = edge_cnt + 1;
        push_ev(t0, EV_P);
        push_ev(t0 + 1, EV_R);
        push_ev(t0 + 5, EV_P);
        push_ev(t0 + 6, EV_R | EV_D);
        drive(1'b1, 1);
        drive(1'b0, 4);
        drive(1'b1, 1);
        drive(1'b0, 8);

        // 5) second press one cycle too late: single, then a fresh click
        t0 = edge_cnt + 1;
        push_ev(t0, EV_P);
        push_ev(t0 + 1, EV_R);
        push_ev(t0 + 5, EV_S);
        push_ev(t0 + 6, EV_P);
        push_ev(t0 + 7, EV_R);
        push_ev(t0 + 11, EV_S);
        drive(1'b1, 1);
        drive(1'b0, 5);
        drive(1'b1, 1);
        drive(1'b0, 10);

        // 6) release on the long-expiry edge: release wins, no long press
        t0 = edge_cnt + 1;
        push_ev(t0, EV_P);
        push_ev(t0 + 8, EV_R);
        push_ev(t0 + 12, EV_S);
        drive(1'b1, 8);
        drive(1'b0, 8);

        // 7) long second press -> long press, no double click
        t0 = edge_cnt + 1;
        push_ev(t0, EV_P);
        push_ev(t0 + 1, EV_R);
        push_ev(t0 + 2, EV_P);
        push_ev(t0 + 10, EV_L);
        push_ev(t0 + 12, EV_R);
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 10);
        drive(1'b0, 6);

        // 8) reset while in SECOND with press_pulse high, button kept down
        t0 = edge_cnt + 1;
        push_ev(t0, EV_P);
        push_ev(t0 + 1, EV_R);
        push_ev(t0 + 2, EV_P);
        push_ev(t0 + 4, EV_P);
        push_ev(t0 + 5, EV_R);
        push_ev(t0 + 9, EV_S);
        drive(1'b1, 1);
        drive(1'b0, 1);
        btn_in = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        total++;
        if ({press_pulse, release_pulse, single_click, double_click, long_press, held} !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid: got %b want 000000",
                     {press_pulse, release_pulse, single_click, double_click, long_press, held});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_bit("held_after_reset", held, 1'b1);
        drive(1'b0, 8);

`ifdef BTN_EVT_COUNT_EN
        // 9) 257 presses from reset -> counter wraps to 1
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_presses = 0;
        drive(1'b0, 2);
        for (int k = 0; k < 257; k++) begin
            t0 = edge_cnt + 1;
            push_ev(t0, EV_P);
            push_ev(t0 + 1, EV_R);
            push_ev(t0 + 5, EV_S);
            drive(1'b1, 1);
            drive(1'b0, 6);
        end
        total++;
        if (press_count !== 8'(exp_presses)) begin
            bad++;
            $display("FAIL press_count: got %0d want %0d", press_count, 8'(exp_presses));
        end
`endif

        drive(1'b0, 4);

        // ---------------- final report ----------------
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL evt_missing: got %0d events left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
